// File: rtl/coherence_bus_arbiter_if.sv
// Bus bundle between the snooping caches and coherence_bus_arbiter:
// requests, snoop broadcast/acks and the completion back to the requester.
interface coherence_bus_arbiter_if #(
  parameter int NUM_CPUS = 4,
  parameter int XLEN     = 6
);
  localparam int SW = $clog2(NUM_CPUS) + 1;

  logic [NUM_CPUS-1:0]      req_valid;
  logic [3*NUM_CPUS-1:0]    req_tx;
  logic [XLEN*NUM_CPUS-1:0] req_addr;
  logic [NUM_CPUS-1:0]      req_ready;

  logic                     bcast_valid;
  logic [SW-1:0]            bcast_source;
  logic [XLEN-1:0]          bcast_addr;
  logic [2:0]               bcast_tx;

  logic [NUM_CPUS-1:0]      snoop_ack;
  logic [NUM_CPUS-1:0]      snoop_shared;

  logic                     resp_valid;
  logic [SW-1:0]            resp_dest;
  logic                     resp_shared;
  logic                     resp_error;

  modport master (
    output req_valid, req_tx, req_addr, snoop_ack, snoop_shared,
    input  req_ready, bcast_valid, bcast_source, bcast_addr, bcast_tx,
           resp_valid, resp_dest, resp_shared, resp_error
  );

  modport slave (
    input  req_valid, req_tx, req_addr, snoop_ack, snoop_shared,
    output req_ready, bcast_valid, bcast_source, bcast_addr, bcast_tx,
           resp_valid, resp_dest, resp_shared, resp_error
  );
endinterface

// File: rtl/coherence_bus_arbiter.sv
// Round-robin snooping-bus arbiter with one transaction in flight.
// Optional snoop watchdog enabled by defining SNOOP_TIMEOUT_EN.
module coherence_bus_arbiter #(
  parameter int NUM_CPUS       = 4,
  parameter int XLEN           = 6,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  coherence_bus_arbiter_if.slave  bus
);
  localparam int SW = $clog2(NUM_CPUS) + 1;

  if (NUM_CPUS < 2 || NUM_CPUS > 16 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("coherence_bus_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, BCAST, WAIT_ACK, RESP} state_t;

  state_t              state;
  logic [SW-1:0]       last_grant;
  logic [SW-1:0]       src;
  logic [XLEN-1:0]     addr_q;
  logic [2:0]          tx_q;
  logic [NUM_CPUS-1:0] ack_mask;
  logic                shared_q;
  logic                bcast_valid_q;
  logic                resp_valid_q;
  logic                resp_shared_q;

  logic [NUM_CPUS-1:0] eligible;
  logic [NUM_CPUS-1:0] rot;
  logic [NUM_CPUS-1:0] grant;
  logic [SW-1:0]       start_idx;
  logic [SW-1:0]       off;
  logic [SW:0]         sum;
  logic [SW-1:0]       grant_idx;
  logic                grant_any;
  logic [XLEN-1:0]     sel_addr;
  logic [2:0]          sel_tx;
  logic [NUM_CPUS-1:0] src_onehot;
  logic [NUM_CPUS-1:0] ack_next;
  logic                shared_next;
  logic                acks_done;

  // Rotate eligibility so the search always begins just after the last grant.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_CPUS; i++) begin
      eligible[i] = bus.req_valid[i] && (bus.req_tx[3*i +: 3] != 3'd0)
                    && (bus.req_tx[3*i +: 3] <= 3'd4);
    end
    start_idx = (last_grant == SW'(NUM_CPUS - 1)) ? '0 : last_grant + 1'b1;
    rot       = NUM_CPUS'({eligible, eligible} >> start_idx);
    grant_any = |eligible;
    off       = '0;
    for (int k = NUM_CPUS - 1; k >= 0; k--) begin
      if (rot[k]) off = SW'(k);
    end
    sum       = {1'b0, start_idx} + {1'b0, off};
    grant_idx = (sum >= (SW+1)'(NUM_CPUS)) ? SW'(sum - (SW+1)'(NUM_CPUS)) : SW'(sum);
    grant     = grant_any ? (NUM_CPUS'(1) << grant_idx) : '0;
    sel_addr  = '0;
    sel_tx    = '0;
    for (int i = 0; i < NUM_CPUS; i++) begin
      if (grant[i]) begin
        sel_addr = bus.req_addr[XLEN*i +: XLEN];
        sel_tx   = bus.req_tx[3*i +: 3];
      end
    end
  end

  // Current-cycle acks count toward completion so RESP follows the last ack directly.
  always_comb begin
    src_onehot  = NUM_CPUS'(1) << src;
    ack_next    = ack_mask | (bus.snoop_ack & ~src_onehot);
    shared_next = shared_q | (|(bus.snoop_ack & bus.snoop_shared & ~src_onehot));
    acks_done   = &(ack_next | src_onehot);
  end

`ifdef SNOOP_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;
  logic          resp_error_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      last_grant    <= SW'(NUM_CPUS - 1);
      src           <= '0;
      addr_q        <= '0;
      tx_q          <= '0;
      ack_mask      <= '0;
      shared_q      <= 1'b0;
      bcast_valid_q <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_shared_q <= 1'b0;
`ifdef SNOOP_TIMEOUT_EN
      tmo_cnt       <= '0;
      resp_error_q  <= 1'b0;
`endif
    end else begin
      bcast_valid_q <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_shared_q <= 1'b0;
`ifdef SNOOP_TIMEOUT_EN
      resp_error_q  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (grant_any) begin
            src           <= grant_idx;
            addr_q        <= sel_addr;
            tx_q          <= sel_tx;
            ack_mask      <= '0;
            shared_q      <= 1'b0;
            bcast_valid_q <= 1'b1;
            state         <= BCAST;
          end
        end
        BCAST: begin
          ack_mask <= ack_next;
          shared_q <= shared_next;
`ifdef SNOOP_TIMEOUT_EN
          tmo_cnt  <= '0;
`endif
          if (tx_q == 3'd4) begin
            resp_valid_q <= 1'b1;
            state        <= RESP;
          end else begin
            state <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          ack_mask <= ack_next;
          shared_q <= shared_next;
          if (acks_done) begin
            resp_valid_q  <= 1'b1;
            resp_shared_q <= shared_next;
            state         <= RESP;
          end
`ifdef SNOOP_TIMEOUT_EN
          else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            resp_valid_q <= 1'b1;
            resp_error_q <= 1'b1;
            state        <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          last_grant <= src;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready    = (state == IDLE && !rst) ? grant : '0;
  assign bus.bcast_valid  = bcast_valid_q;
  assign bus.bcast_source = bcast_valid_q ? src : '0;
  assign bus.bcast_addr   = bcast_valid_q ? addr_q : '0;
  assign bus.bcast_tx     = bcast_valid_q ? tx_q : '0;
  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_dest    = resp_valid_q ? src : '0;
  assign bus.resp_shared  = resp_shared_q;
`ifdef SNOOP_TIMEOUT_EN
  assign bus.resp_error   = resp_error_q;
`else
  assign bus.resp_error   = 1'b0;
`endif
endmodule
